// File: rtl/demux8_pkg.sv
// demux8_pkg: shared state encoding and lane geometry for demux8_seq
package demux8_pkg;
  localparam int LANES = 8;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/demux8_decode.sv
// demux8_decode: 3-to-8 one-hot lane write-enable decoder
module demux8_decode
  import demux8_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [0:LANES-1] oh
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign oh[i] = en && (idx == IDX_W'(i));
  end
endmodule

// File: rtl/demux8_seq.sv
// demux8_seq: registered 1-to-8 demux/deserializer; define DEMUX8_TIMEOUT_EN to abort idle scans after TIMEOUT cycles
module demux8_seq
  import demux8_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic [2:0]       s,
  input  logic             wr,
  input  logic             start,
  input  logic             in_valid,
  output logic [0:7]       a,
  output logic [2:0]       sel,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_t state;
  logic [0:LANES-1] shadow, we, merged, a_wr;
  logic wr_en, cap, last;
  assign wr_en = state == IDLE && !start && wr;
  assign cap = state == SCAN && in_valid;
  assign last = cap && sel == IDX_W'(LANES - 1);
  // one decoder serves both paths: scan index in SCAN, direct address otherwise
  demux8_decode u_dec (
    .idx(state == SCAN ? sel : s),
    .en (wr_en || cap),
    .oh (we)
  );
  assign merged = (we & {LANES{x}}) | (shadow & ~we);
  assign a_wr = (we & {LANES{x}}) | (a & ~we);
`ifdef DEMUX8_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
`else
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shadow <= '0;
      a <= '0;
      sel <= '0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef DEMUX8_TIMEOUT_EN
      err <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef DEMUX8_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            shadow <= '0;
            sel <= '0;
            busy <= 1'b1;
            state <= SCAN;
`ifdef DEMUX8_TIMEOUT_EN
            cnt <= '0;
`endif
          end else if (wr) a <= a_wr;
        end
        SCAN: begin
          if (last) begin
            a <= merged;
            sel <= '0;
            done <= 1'b1;
            state <= DONE;
          end else if (cap) begin
            shadow <= merged;
            sel <= sel + 1'b1;
          end
`ifdef DEMUX8_TIMEOUT_EN
          if (cap) cnt <= '0;
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            err <= 1'b1;
            busy <= 1'b0;
            sel <= '0;
            cnt <= '0;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
`endif
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
